// File: rtl/clk2x_gate_ctrl_if.sv
// Control/status bundle between the host-side controller and the CLK2X BUFGCE gate.
// The master drives requests and the slave (the gate controller) returns CE and status.
interface clk2x_gate_ctrl_if;
    logic        enable_i;
    logic        force_on_i;
    logic        wake_i;
    logic        idle_i;
    logic        ce_o;
    logic        clk_on_o;
    logic        ready_o;
    logic [15:0] gate_cnt_o;

    modport master (
        output enable_i, force_on_i, wake_i, idle_i,
        input  ce_o, clk_on_o, ready_o, gate_cnt_o
    );

    modport slave (
        input  enable_i, force_on_i, wake_i, idle_i,
        output ce_o, clk_on_o, ready_o, gate_cnt_o
    );
endinterface

// File: rtl/clk2x_gate_ctrl.sv
// CE generator for the CLK2X BUFGCE. After DCM settle it wakes the 2x clock on demand,
// gates it off after a programmable idle run, enforces a minimum off-time and counts gate events.
module clk2x_gate_ctrl #(
    parameter int unsigned STARTUP_DELAY = 1024,
    parameter int unsigned IDLE_TIMEOUT  = 256,
    parameter int unsigned MIN_OFF       = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
    clk2x_gate_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_OFF_HOLD,
        S_OFF,
        S_ON,
        S_IDLE_WAIT
    } state_e;

    localparam logic [CNT_WIDTH-1:0] STARTUP_LAST = CNT_WIDTH'(STARTUP_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] OFF_LAST     = CNT_WIDTH'(MIN_OFF - 1);
    localparam logic [CNT_WIDTH-1:0] IDLE_LAST    = CNT_WIDTH'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 wake_pend_q, wake_pend_d;
    logic [1:0]           idle_sync_q;
    logic                 ce_q, ce_d;
    logic                 clk_on_q;
    logic                 ready_q, ready_d;
    logic [15:0]          gate_cnt_q, gate_cnt_d;
    logic                 idle_s;
    logic                 gate_evt;

    assign idle_s = idle_sync_q[1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        gate_evt = 1'b0;

        case (state_q)
            S_STARTUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = S_OFF_HOLD;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OFF_HOLD: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OFF: begin
                if (bus.enable_i && (bus.wake_i || wake_pend_q || bus.force_on_i)) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (!bus.enable_i) begin
                    state_d  = S_OFF_HOLD;
                    cnt_d    = '0;
                    gate_evt = 1'b1;
                end else if (idle_s && !bus.force_on_i && !bus.wake_i) begin
                    state_d = S_IDLE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_IDLE_WAIT: begin
                // Any sign of new work beats a timeout expiring in the same cycle.
                if (!bus.enable_i) begin
                    state_d  = S_OFF_HOLD;
                    cnt_d    = '0;
                    gate_evt = 1'b1;
                end else if (bus.wake_i || bus.force_on_i || !idle_s) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d  = S_OFF_HOLD;
                    cnt_d    = '0;
                    gate_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_STARTUP;
                cnt_d   = '0;
            end
        endcase

        ce_d = (state_d == S_ON) || (state_d == S_IDLE_WAIT);

        gate_cnt_d = gate_cnt_q;
        if (gate_evt && (gate_cnt_q != 16'hFFFF)) begin
            gate_cnt_d = gate_cnt_q + 16'd1;
        end

        // A pending wake is only remembered while the clock is off and the host allows it.
        wake_pend_d = wake_pend_q;
        if (!bus.enable_i) begin
            wake_pend_d = 1'b0;
        end else if (state_d == S_ON && state_q != S_ON) begin
            wake_pend_d = 1'b0;
        end else if (bus.wake_i && !(state_q == S_ON || state_q == S_IDLE_WAIT)) begin
            wake_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_STARTUP;
            cnt_q       <= '0;
            wake_pend_q <= 1'b0;
            idle_sync_q <= 2'b11;
            ce_q        <= 1'b0;
            clk_on_q    <= 1'b0;
            ready_q     <= 1'b0;
            gate_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wake_pend_q <= wake_pend_d;
            idle_sync_q <= {idle_sync_q[0], bus.idle_i};
            ce_q        <= ce_d;
            clk_on_q    <= ce_d;
            ready_q     <= ready_d;
            gate_cnt_q  <= gate_cnt_d;
        end
    end

    assign bus.ce_o       = ce_q;
    assign bus.clk_on_o   = clk_on_q;
    assign bus.ready_o    = ready_q;
    assign bus.gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_clk2x_gate_ctrl.sv
// Bench for clk2x_gate_ctrl: directed scenarios followed by random traffic, all scored
// against a timing-level model built from elapsed-cycle and idle-run counts.
module tb_clk2x_gate_ctrl;

    localparam int STARTUP_DELAY = 16;
    localparam int IDLE_TIMEOUT  = 8;
    localparam int MIN_OFF       = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk2x_gate_ctrl_if bus ();

    clk2x_gate_ctrl #(
        .STARTUP_DELAY (STARTUP_DELAY),
        .IDLE_TIMEOUT  (IDLE_TIMEOUT),
        .MIN_OFF       (MIN_OFF),
        .CNT_WIDTH     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: CE history described as elapsed cycles since reset, remaining off-time
    // and the length of the current uninterrupted idle run while CE is high.
    int          m_since_rst;
    int          m_hold;
    int          m_idle_run;
    bit          m_ready;
    bit          m_ce;
    bit          m_pend;
    bit [15:0]   m_gcnt;
    bit          m_idle_hist [2];

    task automatic model_reset();
        m_since_rst    = 0;
        m_hold         = 0;
        m_idle_run     = 0;
        m_ready        = 1'b0;
        m_ce           = 1'b0;
        m_pend         = 1'b0;
        m_gcnt         = 16'd0;
        m_idle_hist[0] = 1'b1;
        m_idle_hist[1] = 1'b1;
    endtask

    task automatic model_edge(input bit en, input bit fo, input bit wk, input bit idl);
        bit idle_seen;
        bit next_ce;
        bit rise;
        bit fall;
        idle_seen = m_idle_hist[1];
        next_ce   = m_ce;
        rise      = 1'b0;
        fall      = 1'b0;
        if (!m_ready) begin
            m_since_rst++;
            if (m_since_rst == STARTUP_DELAY) begin
                m_ready = 1'b1;
                m_hold  = MIN_OFF;
            end
        end else if (!m_ce) begin
            if (m_hold > 0) m_hold--;
            else if (en && (wk || m_pend || fo)) begin
                rise       = 1'b1;
                m_idle_run = 0;
            end
        end else begin
            if (!en) fall = 1'b1;
            else if (idle_seen && !fo && !wk) begin
                m_idle_run++;
                if (m_idle_run == IDLE_TIMEOUT + 1) fall = 1'b1;
            end else m_idle_run = 0;
        end
        if (rise) next_ce = 1'b1;
        if (fall) begin
            next_ce = 1'b0;
            m_hold  = MIN_OFF;
            if (m_gcnt != 16'hFFFF) m_gcnt++;
        end
        if (!en) m_pend = 1'b0;
        else if (rise) m_pend = 1'b0;
        else if (!m_ce && wk) m_pend = 1'b1;
        m_ce           = next_ce;
        m_idle_hist[1] = m_idle_hist[0];
        m_idle_hist[0] = idl;
    endtask

    task automatic compare_all();
        check("ce", 32'(bus.ce_o), 32'(m_ce));
        check("clk_on", 32'(bus.clk_on_o), 32'(m_ce));
        check("ready", 32'(bus.ready_o), 32'(m_ready));
        check("gate_cnt", 32'(bus.gate_cnt_o), 32'(m_gcnt));
    endtask

    // Called at a falling edge: drive, clock once, advance the model, compare at the next falling edge.
    task automatic step(input bit en, input bit fo, input bit wk, input bit idl);
        bus.enable_i   = en;
        bus.force_on_i = fo;
        bus.wake_i     = wk;
        bus.idle_i     = idl;
        @(posedge clk);
        if (!rst) model_edge(en, fo, wk, idl);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit en, fo, wk, idl;
        bus.enable_i   = 1'b1;
        bus.force_on_i = 1'b1;
        bus.wake_i     = 1'b0;
        bus.idle_i     = 1'b0;
        model_reset();

        @(negedge clk);
        check("rst_ce", 32'(bus.ce_o), 32'd0);
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_gate_cnt", 32'(bus.gate_cnt_o), 32'd0);
        rst = 1'b0;

        // Startup with ENABLE and FORCE_ON already high.
        for (int i = 1; i <= 21; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 15) check("startup_not_ready", 32'(bus.ready_o), 32'd0);
            if (i == 16) check("startup_ready", 32'(bus.ready_o), 32'd1);
            if (i == 20) check("startup_ce_low", 32'(bus.ce_o), 32'd0);
            if (i == 21) check("startup_ce_high", 32'(bus.ce_o), 32'd1);
        end

        // Idle timeout: drop FORCE_ON, raise IDLE.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("idle_timeout_ce", 32'(bus.ce_o), 32'd0);
        check("idle_timeout_gate", 32'(bus.gate_cnt_o), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Wake from OFF, then a second WAKE exactly on the timeout expiry cycle.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("wake_rise", 32'(bus.ce_o), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("wake_at_expiry_ce", 32'(bus.ce_o), 32'd1);
        check("wake_at_expiry_gate", 32'(bus.gate_cnt_o), 32'd1);

        // Timeout again, then WAKE one cycle into the off-hold.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("second_fall", 32'(bus.ce_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("min_off_hold", 32'(bus.ce_o), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("pend_serviced", 32'(bus.ce_o), 32'd1);

        // ENABLE low gates immediately; WAKE while disabled is dropped.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("disable_gate_cnt", 32'(bus.gate_cnt_o), 32'd3);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("no_pend_when_disabled", 32'(bus.ce_o), 32'd0);

        // Saturation of the gate counter.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("forced_on", 32'(bus.ce_o), 32'd1);
        force dut.gate_cnt_q = 16'hFFFF;
        #1 release dut.gate_cnt_q;
        m_gcnt = 16'hFFFF;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("gate_cnt_saturate", 32'(bus.gate_cnt_o), 32'hFFFF);

        // Reset while the clock is running.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("on_before_reset", 32'(bus.ce_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ce", 32'(bus.ce_o), 32'd0);
        check("async_rst_ready", 32'(bus.ready_o), 32'd0);
        check("async_rst_gate_cnt", 32'(bus.gate_cnt_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 15) check("restart_not_ready", 32'(bus.ready_o), 32'd0);
            if (i == 16) check("restart_ready", 32'(bus.ready_o), 32'd1);
        end

        // Random traffic.
        idl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 19) != 0);
            fo  = ($urandom_range(0, 15) == 0);
            wk  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) idl = ~idl;
            step(en, fo, wk, idl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk2x_gate_ctrl.md
Name: clk2x_gate_ctrl

Overview:
- Generates the CE input for the CLK2X BUFGCE of the clock management tile.
- Runs in the free-running CLK0 domain.
- Holds CE low during DCM settle after reset.
- Enables the 2x clock on work requests and gates it off after a programmable idle period, with a minimum off-time to prevent CE chatter.
- Counts gating events for host readout.

Parameters:
- STARTUP_DELAY, 1024, CLK cycles after reset release before CE may assert (DCM settle); must be ≥1.
- IDLE_TIMEOUT, 256, consecutive synchronized-idle cycles in ON before CE deasserts; must be ≥1.
- MIN_OFF, 16, minimum CLK cycles CE stays low after any deassertion; must be ≥1.
- CNT_WIDTH, 16, width of internal delay counter; must hold max(STARTUP_DELAY, IDLE_TIMEOUT, MIN_OFF).

Ports:
- CLK  in  1  CLK0 from clock tile; only clock of this block.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  host master enable, CLK-synchronous; 0 forces CE off.
- FORCE_ON  in  1  keep clock running regardless of idle, CLK-synchronous.
- WAKE  in  1  single-cycle pulse, work pending for the 2x domain, CLK-synchronous.
- IDLE  in  1  consumer idle flag from the CLK2X domain, asynchronous to CLK; 2-FF synchronized internally.
- CE  out  1  registered clock enable to BUFGCE.
- CLK_ON  out  1  registered; 1 in ON or IDLE_WAIT.
- READY  out  1  registered; 1 once STARTUP_DELAY has elapsed.
- GATE_CNT  out  16  saturating count of CE 1→0 transitions.

Behaviour:
- Reset (async assert): state=STARTUP, counter=0, wake_pend=0, idle sync FFs=1, CE=0, CLK_ON=0, READY=0, GATE_CNT=0.
- idle_s = IDLE after 2-FF sync; an IDLE change is visible to the FSM 2 CLK edges later.
- All outputs are registered; a CE change appears on the edge at which the FSM transition is taken.
- wake_pend:
  - Set by WAKE in any state other than ON/IDLE_WAIT.
  - Cleared on entry to ON.
  - Forced to 0 while ENABLE=0.
- STARTUP:
  - CE=0; counter increments each cycle.
  - At counter==STARTUP_DELAY-1 → OFF_HOLD, counter=0, READY←1 (READY remains 1 until reset).
  - ENABLE, WAKE and FORCE_ON are ignored, except that WAKE sets wake_pend.
- OFF_HOLD:
  - CE=0; counter increments.
  - At counter==MIN_OFF-1 → OFF.
  - Not exited early for any input.
- OFF:
  - CE=0.
  - If ENABLE && (WAKE || wake_pend || FORCE_ON) → ON: CE←1, CLK_ON←1.
- ON:
  - CE=1.
  - If !ENABLE → OFF_HOLD, counter=0, CE←0, GATE_CNT++.
  - Else if idle_s && !FORCE_ON && !WAKE → IDLE_WAIT, counter=0.
- IDLE_WAIT:
  - CE=1; counter increments.
  - Priority, highest first:
    - !ENABLE → OFF_HOLD with gate event.
    - WAKE || FORCE_ON || !idle_s → ON.
    - counter==IDLE_TIMEOUT-1 → OFF_HOLD, counter=0, CE←0, GATE_CNT++.
  - Total CE-high time after idle_s first seen: IDLE_TIMEOUT+1 cycles (1 cycle in ON, then IDLE_TIMEOUT cycles in IDLE_WAIT).
- Gate event: every CE 1→0 transition. GATE_CNT saturates at 16'hFFFF and never wraps.
- Simultaneous WAKE and timeout expiry in IDLE_WAIT: WAKE wins; CE stays 1.
- Simultaneous !ENABLE and WAKE: !ENABLE wins; wake_pend is not set.
- RST asserted mid-operation: CE drops asynchronously to 0 and the full STARTUP_DELAY repeats. GATE_CNT is not incremented for this drop.
- CE never glitches. CE never rises less than MIN_OFF cycles after it falls, nor before READY.

Test Plan (STARTUP_DELAY=16, IDLE_TIMEOUT=8, MIN_OFF=4):
- Release RST at cycle 0 with ENABLE=1, FORCE_ON=1 → READY=1 after edge 16; OFF_HOLD lasts 4 cycles; CE=1 after edge 21; CE=0 throughout cycles 0-20.
- From OFF with IDLE=1, pulse WAKE → CE=1 next edge; CE holds for IDLE_TIMEOUT+1=9 cycles once idle_s is seen (including sync latency, IDLE must be 1 for 11 cycles); then CE=0 and GATE_CNT 0→1.
- In IDLE_WAIT at counter=7 (expiry cycle), pulse WAKE → CE stays 1, state=ON, GATE_CNT unchanged.
- After CE falls, pulse WAKE 1 cycle later → CE stays 0 for exactly 4 cycles (OFF_HOLD), OFF entered, wake_pend serviced, CE=1 on the next edge.
- Drive ENABLE=0 while CE=1 → CE=0 next edge, GATE_CNT+1; then WAKE with ENABLE=0 → CE stays 0; raise ENABLE with no WAKE → CE stays 0.
- Preload GATE_CNT to 16'hFFFF (force), trigger a gate event → GATE_CNT=16'hFFFF. Assert RST mid-ON → CE=0 immediately, READY=0, GATE_CNT=0, and the 16-cycle startup repeats.
